control_unit_id: RTL and testbench

CONTROL_UNIT_ID -- requirements
Module: control_unit_id

---
 rtl/control_unit_id.sv | 191 +++++++++++++++++++
 tb/tb_control_unit_id.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/control_unit_id.sv
// ID-stage main control decoder with registered ID/EX outputs.
// Illegal instructions park the unit in a trap state until the handler acknowledges.
module control_unit_id (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       stall,
  input  logic       flush,
  input  logic       trap_ack,
  output logic [2:0] aluop,
  output logic [5:0] opcode_lsb,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       shamt_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       jump,
  output logic       jump_reg,
  output logic       link,
  output logic       valid_out,
  output logic       trap_pending
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic [5:0] opcode_lsb;
    logic       reg_dst;
    logic       alu_src;
    logic       shamt_sel;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic       valid_out;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, dec;
  logic   legal;

  // Pure decode of the ID instruction; qualified by the FSM below.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      6'b000000: begin
        dec.aluop      = 3'b000;
        dec.opcode_lsb = funct;
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            legal         = 1'b1;
            dec.shamt_sel = 1'b1;
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
          end
          6'b000100, 6'b000110, 6'b000111, 6'b100001, 6'b100011, 6'b100100,
          6'b100101, 6'b100110, 6'b100111, 6'b101010: begin
            legal         = 1'b1;
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
          end
          6'b001000: begin
            legal        = 1'b1;
            dec.jump_reg = 1'b1;
          end
          6'b001001: begin
            legal         = 1'b1;
            dec.jump_reg  = 1'b1;
            dec.link      = 1'b1;
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      6'b000010: begin
        legal     = 1'b1;
        dec.aluop = 3'b001;
        dec.jump  = 1'b1;
      end
      6'b000011: begin
        legal         = 1'b1;
        dec.aluop     = 3'b001;
        dec.jump      = 1'b1;
        dec.link      = 1'b1;
        dec.reg_write = 1'b1;
      end
      6'b000100: begin
        legal      = 1'b1;
        dec.aluop  = 3'b110;
        dec.branch = 1'b1;
      end
      6'b000101: begin
        legal         = 1'b1;
        dec.aluop     = 3'b110;
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        legal         = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (opcode)
          6'b001100: dec.aluop = 3'b010;
          6'b001101: dec.aluop = 3'b011;
          6'b001110: dec.aluop = 3'b100;
          6'b001111: dec.aluop = 3'b111;
          default:   dec.aluop = 3'b001;
        endcase
      end
      6'b100000, 6'b100011: begin
        legal          = 1'b1;
        dec.aluop      = 3'b001;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      6'b101000, 6'b101011: begin
        legal         = 1'b1;
        dec.aluop     = 3'b001;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.valid_out = legal;
  end

  // Bubble is the all-zero control word; flush/stall/empty slot win over trap entry.
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;
    case (state_q)
      StRun: begin
        if (flush || stall || !instr_valid) begin
          ctrl_d = '0;
        end else if (!legal) begin
          state_d = StTrap;
        end else begin
          ctrl_d = dec;
        end
      end
      StTrap: begin
        if (trap_ack) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign aluop        = ctrl_q.aluop;
  assign opcode_lsb   = ctrl_q.opcode_lsb;
  assign reg_dst      = ctrl_q.reg_dst;
  assign alu_src      = ctrl_q.alu_src;
  assign shamt_sel    = ctrl_q.shamt_sel;
  assign mem_read     = ctrl_q.mem_read;
  assign mem_write    = ctrl_q.mem_write;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign reg_write    = ctrl_q.reg_write;
  assign branch       = ctrl_q.branch;
  assign branch_ne    = ctrl_q.branch_ne;
  assign jump         = ctrl_q.jump;
  assign jump_reg     = ctrl_q.jump_reg;
  assign link         = ctrl_q.link;
  assign valid_out    = ctrl_q.valid_out;
  assign trap_pending = (state_q == StTrap);

endmodule

// File: tb/tb_control_unit_id.sv
// Directed-vector bench for control_unit_id; expected control words are hand-written constants.
module tb_control_unit_id;

  logic       clk, rst_n;
  logic       instr_valid, stall, flush, trap_ack;
  logic [5:0] opcode, funct;
  logic [2:0] aluop;
  logic [5:0] opcode_lsb;
  logic       reg_dst, alu_src, shamt_sel, mem_read, mem_write, mem_to_reg, reg_write;
  logic       branch, branch_ne, jump, jump_reg, link, valid_out, trap_pending;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Flag masks in the low 14 bits of the observed word.
  localparam logic [13:0] RD = 14'h2000, AS = 14'h1000, SH = 14'h0800, MR = 14'h0400;
  localparam logic [13:0] MW = 14'h0200, M2R = 14'h0100, RW = 14'h0080, BR = 14'h0040;
  localparam logic [13:0] BNE = 14'h0020, JP = 14'h0010, JR = 14'h0008, LK = 14'h0004;
  localparam logic [13:0] VO = 14'h0002, TP = 14'h0001;
  localparam logic [22:0] BUBBLE = 23'd0;

  control_unit_id dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .funct        (funct),
    .stall        (stall),
    .flush        (flush),
    .trap_ack     (trap_ack),
    .aluop        (aluop),
    .opcode_lsb   (opcode_lsb),
    .reg_dst      (reg_dst),
    .alu_src      (alu_src),
    .shamt_sel    (shamt_sel),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .branch       (branch),
    .branch_ne    (branch_ne),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .link         (link),
    .valid_out    (valid_out),
    .trap_pending (trap_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] ev(input logic [2:0] a, input logic [5:0] l,
                                     input logic [13:0] f);
    return {a, l, f};
  endfunction

  function automatic logic [22:0] obs();
    return {aluop, opcode_lsb, reg_dst, alu_src, shamt_sel, mem_read, mem_write, mem_to_reg,
            reg_write, branch, branch_ne, jump, jump_reg, link, valid_out, trap_pending};
  endfunction

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Present an instruction, clock it in, then sample 1 time unit after the edge.
  task automatic apply(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl, input logic ta);
    instr_valid = v;
    opcode      = op;
    funct       = fn;
    stall       = st;
    flush       = fl;
    trap_ack    = ta;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b1; opcode = 6'b100011; funct = 6'd0;
    stall = 1'b0; flush = 1'b0; trap_ack = 1'b0;
    @(posedge clk); #1;
    check("reset_state", obs(), BUBBLE);
    rst_n = 1'b1;

    apply(1, 6'b100011, 6'd0, 0, 0, 0);
    check("lw", obs(), ev(3'b001, 6'd0, AS | MR | M2R | RW | VO));
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), BUBBLE);
    #1 rst_n = 1'b1;

    apply(1, 6'b000000, 6'b100011, 0, 0, 0);
    check("r_subu", obs(), ev(3'b000, 6'b100011, RD | RW | VO));
    apply(1, 6'b001111, 6'd0, 0, 0, 0);
    check("lui", obs(), ev(3'b111, 6'd0, AS | RW | VO));
    apply(1, 6'b101011, 6'd0, 0, 0, 0);
    check("sw", obs(), ev(3'b001, 6'd0, AS | MW | VO));

    apply(1, 6'b100011, 6'd0, 1, 0, 0);
    check("stall_lw", obs(), BUBBLE);
    apply(1, 6'b100011, 6'd0, 0, 0, 0);
    check("lw_after_stall", obs(), ev(3'b001, 6'd0, AS | MR | M2R | RW | VO));
    apply(0, 6'b001000, 6'd0, 0, 0, 0);
    check("not_valid", obs(), BUBBLE);

    apply(1, 6'b111111, 6'd0, 0, 0, 0);
    check("illegal_op", obs(), ev(3'b000, 6'd0, TP));
    for (int i = 0; i < 3; i++) begin
      apply(1, 6'b000100, 6'd0, 0, 0, 0);
      check("trap_hold_beq", obs(), ev(3'b000, 6'd0, TP));
    end
    apply(1, 6'b000100, 6'd0, 0, 0, 1);
    check("trap_ack", obs(), BUBBLE);
    apply(1, 6'b000100, 6'd0, 0, 0, 0);
    check("beq", obs(), ev(3'b110, 6'd0, BR | VO));

    apply(1, 6'b111111, 6'd0, 0, 1, 0);
    check("flush_beats_illegal", obs(), BUBBLE);
    apply(1, 6'b000101, 6'd0, 0, 0, 0);
    check("bne", obs(), ev(3'b110, 6'd0, BR | BNE | VO));
    apply(1, 6'b000000, 6'b001010, 0, 0, 0);
    check("illegal_funct", obs(), ev(3'b000, 6'd0, TP));
    apply(1, 6'b001101, 6'd0, 1, 1, 0);
    check("trap_ignores_flush", obs(), ev(3'b000, 6'd0, TP));

    rst_n = 1'b0;
    #1;
    check("reset_in_trap", obs(), BUBBLE);
    #1 rst_n = 1'b1;
    apply(1, 6'b000011, 6'd0, 0, 0, 0);
    check("jal", obs(), ev(3'b001, 6'd0, JP | LK | RW | VO));

    apply(1, 6'b001101, 6'd0, 0, 0, 1);
    check("ori_ack_ignored", obs(), ev(3'b011, 6'd0, AS | RW | VO));
    apply(1, 6'b000000, 6'b000011, 0, 0, 0);
    check("sra_shamt", obs(), ev(3'b000, 6'b000011, RD | SH | RW | VO));
    apply(1, 6'b000000, 6'b000111, 0, 0, 0);
    check("srav_no_shamt", obs(), ev(3'b000, 6'b000111, RD | RW | VO));
    apply(1, 6'b000000, 6'b001000, 0, 0, 0);
    check("jr", obs(), ev(3'b000, 6'b001000, JR | VO));
    apply(1, 6'b000000, 6'b001001, 0, 0, 0);
    check("jalr", obs(), ev(3'b000, 6'b001001, JR | LK | RW | RD | VO));
    apply(1, 6'b000010, 6'd0, 0, 0, 0);
    check("j", obs(), ev(3'b001, 6'd0, JP | VO));
    apply(1, 6'b001100, 6'b111111, 0, 0, 0);
    check("andi", obs(), ev(3'b010, 6'd0, AS | RW | VO));
    apply(1, 6'b001110, 6'd0, 0, 0, 0);
    check("xori", obs(), ev(3'b100, 6'd0, AS | RW | VO));
    apply(1, 6'b001000, 6'd0, 0, 0, 0);
    check("addi", obs(), ev(3'b001, 6'd0, AS | RW | VO));
    apply(1, 6'b100000, 6'd0, 0, 0, 0);
    check("lb", obs(), ev(3'b001, 6'd0, AS | MR | M2R | RW | VO));
    apply(1, 6'b101000, 6'd0, 0, 0, 0);
    check("sb", obs(), ev(3'b001, 6'd0, AS | MW | VO));
    apply(1, 6'b000000, 6'b000000, 1, 0, 0);
    check("stall_sll", obs(), BUBBLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
